// File: rtl/i2s_rx_frame_ctrl_if.sv
// Bus bundle for the I2S receive frame sequencer.
// The master modport is the sequencer side; the slave modport is the sample consumer / ADC side.
interface i2s_rx_frame_ctrl_if #(
  parameter int AUDIO_DW = 16
);
  logic                en;
  logic                sdata;
  logic                lrclk;
  logic                busy;
  logic [AUDIO_DW-1:0] left_chan;
  logic [AUDIO_DW-1:0] right_chan;
  logic                sample_valid;

  modport master (
    input  en,
    input  sdata,
    output lrclk,
    output busy,
    output left_chan,
    output right_chan,
    output sample_valid
  );

  modport slave (
    output en,
    output sdata,
    input  lrclk,
    input  busy,
    input  left_chan,
    input  right_chan,
    input  sample_valid
  );
endinterface

// File: rtl/i2s_rx_frame_ctrl.sv
// Master-mode I2S receive sequencer: generates lrclk, deserialises sdata, strobes one sample pair per frame.
// Define I2S_RX_FRAME_CTRL_LJ_EN for left-justified framing (inverted lrclk, no one-bit delay).
module i2s_rx_frame_ctrl #(
  parameter int AUDIO_DW    = 16,
  parameter int SLOT_W      = 32,
  parameter int SKIP_FRAMES = 2
) (
  input logic                 sclk,
  input logic                 rst,
  i2s_rx_frame_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef I2S_RX_FRAME_CTRL_LJ_EN
  localparam logic LR_LEFT = 1'b1;
  localparam int   CAP_LO  = 0;
`else
  localparam logic LR_LEFT = 1'b0;
  localparam int   CAP_LO  = 1;
`endif
  // The right-channel level doubles as the idle level in both framings.
  localparam logic LR_RIGHT = ~LR_LEFT;
  localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(CAP_LO);
  localparam logic [CNT_W-1:0] CAP_SPAN  = CNT_W'(AUDIO_DW - 1);
  localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(CAP_LO + AUDIO_DW - 1);
  localparam logic [3:0]       SKIP_N    = 4'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam state_t START_ST = (SKIP_FRAMES > 0) ? ST_WARM : ST_RUN;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_bitcnt;
  logic [3:0]          r_skipcnt;
  logic                r_lrclk;
  logic                r_busy;
  logic                r_valid;
  logic [AUDIO_DW-1:0] r_sr_left;
  logic [AUDIO_DW-1:0] r_sr_right;
  logic [AUDIO_DW-1:0] r_left;
  logic [AUDIO_DW-1:0] r_right;
  logic                w_frame_end;
  logic                w_in_window;
  logic                w_load;
  logic                w_stop;

  assign w_frame_end = (r_lrclk == LR_RIGHT) && (r_bitcnt == CNT_LAST);
  assign w_in_window = (CNT_W'(r_bitcnt - CAP_FIRST) <= CAP_SPAN);
  assign w_load      = (r_state == ST_RUN) && (r_lrclk == LR_RIGHT) && (r_bitcnt == CAP_LAST);
  assign w_stop      = w_frame_end && !bus.en;

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stop at a frame end outranks the warm-up to run transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.en) begin
          w_state_nxt = START_ST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WARM: begin
        if (w_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_frame_end && ((r_skipcnt + 4'd1) == SKIP_N)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_WARM;
        end
      end
      ST_RUN: begin
        if (w_stop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      r_bitcnt   <= {CNT_W{1'b0}};
      r_skipcnt  <= 4'd0;
      r_lrclk    <= LR_RIGHT;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_sr_left  <= {AUDIO_DW{1'b0}};
      r_sr_right <= {AUDIO_DW{1'b0}};
      r_left     <= {AUDIO_DW{1'b0}};
      r_right    <= {AUDIO_DW{1'b0}};
    end else begin
      r_valid <= 1'b0;
      r_busy  <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_bitcnt  <= {CNT_W{1'b0}};
          r_skipcnt <= 4'd0;
          r_lrclk   <= bus.en ? LR_LEFT : LR_RIGHT;
        end
        ST_WARM, ST_RUN: begin
          if (r_bitcnt == CNT_LAST) begin
            r_bitcnt <= {CNT_W{1'b0}};
            r_lrclk  <= w_stop ? LR_RIGHT : ~r_lrclk;
          end else begin
            r_bitcnt <= r_bitcnt + CNT_ONE;
          end
          if (w_in_window) begin
            if (r_lrclk == LR_LEFT) begin
              r_sr_left <= {r_sr_left[AUDIO_DW-2:0], bus.sdata};
            end else begin
              r_sr_right <= {r_sr_right[AUDIO_DW-2:0], bus.sdata};
            end
          end
          // The right LSB is still on sdata at the load edge, so splice it in directly.
          if (w_load) begin
            r_left  <= r_sr_left;
            r_right <= {r_sr_right[AUDIO_DW-2:0], bus.sdata};
            r_valid <= 1'b1;
          end
          if (w_frame_end && (r_state == ST_WARM)) begin
            r_skipcnt <= r_skipcnt + 4'd1;
          end
        end
        default: begin
          r_bitcnt <= {CNT_W{1'b0}};
          r_lrclk  <= LR_RIGHT;
        end
      endcase
    end
  end

  assign bus.lrclk        = r_lrclk;
  assign bus.busy         = r_busy;
  assign bus.left_chan    = r_left;
  assign bus.right_chan   = r_right;
  assign bus.sample_valid = r_valid;
endmodule
